// File: rtl/counter_pkg.sv
// counter_pkg: shared state encoding and default widths for the counter blocks
package counter_pkg;
  localparam int DEFAULT_SIZE = 8;
  localparam int DEFAULT_STEP_WIDTH = 4;
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    UP_BUSY   = 2'b01,
    DOWN_BUSY = 2'b10
  } state_t;
endpackage

// File: rtl/step_bound_alu.sv
// step_bound_alu: one bounded step up or down with wrap/saturate and crossing flags
module step_bound_alu
  import counter_pkg::*;
#(
  parameter int SIZE       = DEFAULT_SIZE,
  parameter int STEP_WIDTH = DEFAULT_STEP_WIDTH
) (
  input  logic [SIZE-1:0]       counter,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [SIZE-1:0]       limit_low,
  input  logic [SIZE-1:0]       limit_high,
  input  logic                  wrap,
  input  logic                  dir_up,
  output logic [SIZE-1:0]       next_value,
  output logic                  overflow,
  output logic                  underflow
);
  logic [SIZE:0] sum;
  logic [SIZE:0] diff;
  logic          over;
  logic          under;
  // one extra bit holds the carry of the sum and the borrow of the difference
  always_comb begin
    sum        = {1'b0, counter} + (SIZE+1)'(step);
    diff       = {1'b0, counter} - (SIZE+1)'(step);
    over       = sum > {1'b0, limit_high};
    under      = diff[SIZE] || (diff[SIZE-1:0] < limit_low);
    overflow   = dir_up && over;
    underflow  = !dir_up && under;
    next_value = dir_up ? (over  ? (wrap ? limit_low : limit_high) : sum[SIZE-1:0])
                        : (under ? (wrap ? limit_high : limit_low) : diff[SIZE-1:0]);
  end
endmodule

// File: rtl/bounded_step_counter.sv
// bounded_step_counter: handshaked up/down counter with step, bounds, wrap/saturate and load
module bounded_step_counter
  import counter_pkg::*;
#(
  parameter int              SIZE        = DEFAULT_SIZE,
  parameter int              STEP_WIDTH  = DEFAULT_STEP_WIDTH,
  parameter logic [SIZE-1:0] RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  up,
  input  logic                  down,
  input  logic                  load,
  input  logic [SIZE-1:0]       data,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [SIZE-1:0]       limitLow,
  input  logic [SIZE-1:0]       limitHigh,
  input  logic                  wrap,
  output logic                  upAck,
  output logic                  downAck,
  output logic [SIZE-1:0]       counter,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  atHigh,
  output logic                  atLow,
  output logic                  configError
);
  state_t          state;
  state_t          state_next;
  logic            accept_up;
  logic            accept_down;
  logic            apply;
  logic [SIZE-1:0] alu_value;
  logic            alu_ovf;
  logic            alu_udf;
  logic [SIZE-1:0] clamped;
  logic [SIZE-1:0] counter_next;
  logic            ovf_next;
  logic            udf_next;
  assign upAck       = state == UP_BUSY;
  assign downAck     = state == DOWN_BUSY;
  assign atHigh      = counter == limitHigh;
  assign atLow       = counter == limitLow;
  assign configError = limitLow > limitHigh;
  step_bound_alu #(.SIZE(SIZE), .STEP_WIDTH(STEP_WIDTH)) u_alu (
    .counter    (counter),
    .step       (step),
    .limit_low  (limitLow),
    .limit_high (limitHigh),
    .wrap       (wrap),
    .dir_up     (accept_up),
    .next_value (alu_value),
    .overflow   (alu_ovf),
    .underflow  (alu_udf)
  );
  // handshake FSM; arithmetic only on an accepting edge, and load overrides it
  always_comb begin
    accept_up    = (state == IDLE) && up;
    accept_down  = (state == IDLE) && !up && down;
    state_next   = accept_up ? UP_BUSY : accept_down ? DOWN_BUSY
                 : ((state == UP_BUSY && !up) || (state == DOWN_BUSY && !down)) ? IDLE : state;
    apply        = (accept_up || accept_down) && (step != '0) && !configError && !load;
    clamped      = configError ? data : (data < limitLow) ? limitLow
                 : (data > limitHigh) ? limitHigh : data;
    counter_next = load ? clamped : apply ? alu_value : counter;
    ovf_next     = apply && alu_ovf;
    udf_next     = apply && alu_udf;
  end
  // state, value and single-cycle event pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= RESET_VALUE;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      overflow  <= ovf_next;
      underflow <= udf_next;
    end
  end
endmodule

// File: doc/bounded_step_counter.md
# bounded_step_counter

Parametrised up/down counter with a 4-phase request/acknowledge handshake, a programmable step, runtime inclusive bounds, and a selectable wrap or saturate mode. It extends the basic single-step up/down counter with:
- bounds and step control;
- overflow/underflow event pulses;
- a full handshake, so a held request counts exactly once.

It sits between control FSMs or debounced button logic and any register that needs a bounded position, volume or index value.

## Interface
- SIZE, 8, counter and bound width in bits
- STEP_WIDTH, 4, width of step input
- RESET_VALUE, 0, counter value after reset; must fit in SIZE bits
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- up  in  1  increment request; level, held until upAck
- down  in  1  decrement request; level, held until downAck
- load  in  1  synchronous load strobe
- data  in  SIZE  load value
- step  in  STEP_WIDTH  increment/decrement magnitude, unsigned
- limitLow  in  SIZE  lower bound, inclusive
- limitHigh  in  SIZE  upper bound, inclusive
- wrap  in  1  1 = wrap at bounds, 0 = saturate
- upAck  out  1  high while an accepted up request is pending release
- downAck  out  1  high while an accepted down request is pending release
- counter  out  SIZE  current value, registered
- overflow  out  1  one-cycle pulse when an up operation crossed limitHigh
- underflow  out  1  one-cycle pulse when a down operation crossed limitLow
- atHigh  out  1  counter == limitHigh (combinational from registers and inputs)
- atLow  out  1  counter == limitLow (combinational)
- configError  out  1  limitLow > limitHigh (combinational)

## Operation
- States: IDLE, UP_BUSY, DOWN_BUSY. upAck = (state==UP_BUSY), downAck = (state==DOWN_BUSY).
- IDLE:
  - up=1 → apply up operation, go UP_BUSY.
  - else down=1 → apply down operation, go DOWN_BUSY.
  - Up has priority when both requests are high; down is ignored, not queued.
- UP_BUSY: stay until up=0, then IDLE. down is ignored. DOWN_BUSY mirrors this with the down request.
- Up operation:
  - sum = counter + step, computed in SIZE+1 bits.
  - If sum > limitHigh: wrap=1 → counter ← limitLow; wrap=0 → counter ← limitHigh. Either way overflow pulses.
  - Otherwise counter ← sum[SIZE-1:0].
- Down operation:
  - diff = counter − step, computed in SIZE+1 bits, signed borrow.
  - If borrow, or diff < limitLow: wrap=1 → counter ← limitHigh; wrap=0 → counter ← limitLow. Either way underflow pulses.
  - Otherwise counter ← diff.
- step=0: the request is acknowledged normally; counter is unchanged and no flags are raised.
- configError=1: requests are still acknowledged; counter holds; no overflow/underflow.
- load (any state): counter ← data clamped to [limitLow, limitHigh] (data itself when configError=1).
  - State is unaffected.
  - load wins over a same-cycle up/down; the state still advances to BUSY so the handshake completes, but no arithmetic is applied.
- Limits may change at runtime. They are used combinationally at each accepting edge; counter is not re-clamped until the next operation.

## Timing
- Reset (reset=0, asynchronous): counter=RESET_VALUE, state=IDLE, upAck=downAck=0, overflow=underflow=0.
- Request sampled at rising edge N in IDLE: counter, ack and the overflow/underflow pulse are all valid after edge N (single-cycle latency).
- Ack stays high until the first edge at which the request is seen low; the ack falls after that edge.
- Minimum request period: 2 cycles (accept edge, release edge).
- overflow/underflow: exactly one cycle wide.
- load: counter valid after the sampling edge.
- Reset asserted mid-handshake: ack drops immediately. If the request is still high when reset releases, it is accepted as a new request at the first edge.

## Structure
- Shared package counter_pkg:
  - state encoding localparams IDLE=2'b00, UP_BUSY=2'b01, DOWN_BUSY=2'b10;
  - default SIZE/STEP_WIDTH constants, shared with the existing counter blocks.
- Sub-module step_bound_alu (combinational):
  - inputs counter, step, limits, wrap, direction;
  - outputs next value, overflow, underflow.
- Top level holds the FSM, registers and load clamp.

## Test plan
- Reset with RESET_VALUE=5: counter=5, acks 0. Hold up for 6 cycles with step=1 → counter=6, one upAck pulse train; release → second request gives 7.
- limits 10..20, wrap=0, counter=18, step=4, up → counter=20, overflow pulse, atHigh=1.
- Same limits, wrap=1, counter=12, step=3, down → counter=20, underflow pulse. counter=0, step=1, down → 20 (borrow case).
- up and down raised together at counter=15, step=2 → counter=17, upAck only. load data=30 same cycle as up → counter=20 (clamped), upAck asserted.
- limitLow=40, limitHigh=30 → configError=1. up request is acknowledged, counter unchanged, no flags.
- Assert reset while upAck=1 and up held → ack falls asynchronously. After release, counter=RESET_VALUE+step at the first edge.
